// File: rtl/seq_alu_pkg.sv
// rtl/seq_alu_pkg.sv - opcode and FSM state types shared by the sequential ALU
package seq_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/seq_alu_div.sv
// rtl/seq_alu_div.sv - iterative restoring divider, one quotient bit per cycle
// quotient/remainder reflect the step being taken this cycle; they are final while done is high.
module seq_alu_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] rem_n, quo_n;
  logic [WIDTH:0]   shifted, trial;
  logic [CW-1:0]    cnt;
  logic             busy;

  // A clear top bit of trial means the shifted remainder covers the divisor.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    trial   = shifted - {1'b0, dvs};
    if (!trial[WIDTH]) begin
      rem_n = trial[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_n = shifted[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b0};
    end
  end

  assign done      = busy && (cnt == CW'(WIDTH - 1));
  assign quotient  = quo_n;
  assign remainder = rem_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
      cnt  <= '0;
      rem  <= '0;
      quo  <= '0;
      dvs  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
      rem  <= '0;
      quo  <= dividend;
      dvs  <= divisor;
    end else if (busy) begin
      rem <= rem_n;
      quo <= quo_n;
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - handshaked ADD/SUB/MUL/DIV unit with IDLE/BUSY/DONE FSM
// SEQ_ALU_DIV_EN builds the iterative divider; without it DIV reports div_zero with out=0.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [1:0]         opcode,
  output logic [2*WIDTH-1:0] out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               div_zero
);

  state_e             state, state_n;
  op_e                op;
  logic [2*WIDTH-1:0] out_r, alu_res;
  logic               dz_r, alu_dz;
  logic               accept, go_busy, div_done;
  logic [WIDTH-1:0]   div_q, div_r;

  assign op        = op_e'(opcode);
  assign in_ready  = (state == S_IDLE) || (state == S_DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == S_DONE);
  assign out       = out_r;
  assign div_zero  = dz_r;

`ifdef SEQ_ALU_DIV_EN
  assign go_busy = (op == OP_DIV) && (in2 != '0);

  seq_alu_div #(.WIDTH(WIDTH)) u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && go_busy),
    .dividend  (in1),
    .divisor   (in2),
    .done      (div_done),
    .quotient  (div_q),
    .remainder (div_r)
  );
`else
  assign go_busy  = 1'b0;
  assign div_done = 1'b0;
  assign div_q    = '0;
  assign div_r    = '0;
`endif

  // Single-cycle results; for DIV this is the divide-by-zero (or divider-less) outcome.
  always_comb begin
    alu_res = '0;
    alu_dz  = 1'b0;
    case (op)
      OP_ADD: alu_res = {{WIDTH{1'b0}}, in1} + {{WIDTH{1'b0}}, in2};
      OP_SUB: alu_res = {{WIDTH{1'b0}}, in1} - {{WIDTH{1'b0}}, in2};
      OP_MUL: alu_res = {{WIDTH{1'b0}}, in1} * {{WIDTH{1'b0}}, in2};
      OP_DIV: begin
        alu_dz = 1'b1;
`ifdef SEQ_ALU_DIV_EN
        alu_res = {in1, {WIDTH{1'b1}}};
`else
        alu_res = '0;
`endif
      end
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = go_busy ? S_BUSY : S_DONE;
      S_BUSY: if (div_done) state_n = S_DONE;
      S_DONE: begin
        if (accept)         state_n = go_busy ? S_BUSY : S_DONE;
        else if (out_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      out_r <= '0;
      dz_r  <= 1'b0;
    end else begin
      state <= state_n;
      if (accept && !go_busy) begin
        out_r <= alu_res;
        dz_r  <= alu_dz;
      end else if (state == S_BUSY && div_done) begin
        out_r <= {div_r, div_q};
        dz_r  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - randomized and directed bench for seq_alu against an arithmetic reference
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in1, in2;
  logic [1:0]  opcode;
  logic [15:0] out;
  logic        out_valid;
  logic        out_ready;
  logic        div_zero;

  int total = 0;
  int bad   = 0;
  logic [15:0] last_out;
  logic        last_dz;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .opcode    (opcode),
    .out       (out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .div_zero  (div_zero)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: results from plain integer arithmetic, latency from the operation class.
  task automatic model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [15:0] r, output logic dz, output int lat);
    int ai, bi;
    ai = a; bi = b;
    dz = 1'b0; lat = 1;
    case (op)
      2'd0: r = 16'(ai + bi);
      2'd1: r = 16'(ai - bi);
      2'd2: r = 16'(ai * bi);
      default: begin
`ifdef SEQ_ALU_DIV_EN
        if (bi == 0) begin
          r = {a, 8'hFF}; dz = 1'b1;
        end else begin
          r = {8'(ai % bi), 8'(ai / bi)}; lat = 9;
        end
`else
        r = 16'h0000; dz = 1'b1;
`endif
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b, input int hold);
    logic [15:0] er;
    logic        ed;
    int          el, lat;
    model(op, a, b, er, ed, el);
    @(negedge clk);
    chk("pre_ready", in_ready, 1);
    in_valid = 1'b1; opcode = op; in1 = a; in2 = b; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in1 = 8'($urandom); in2 = 8'($urandom); opcode = 2'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      chk("busy_ready", in_ready, 0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, el);
    chk("out", out, er);
    chk("div_zero", div_zero, ed);
    for (int i = 0; i < hold; i++) begin
      chk("hold_ready", in_ready, 0);
      @(negedge clk);
      chk("hold_valid", out_valid, 1);
      chk("hold_out", out, er);
      chk("hold_dz", div_zero, ed);
    end
    last_out = out; last_dz = div_zero;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    logic seen;
    rst = 1'b1; in_valid = 1'b0; in1 = '0; in2 = '0; opcode = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out", out, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_dz", div_zero, 0);
    chk("rst_ready", in_ready, 1);

    run_op(2'd0, 8'd200, 8'd100, 0); chk("add_200_100", last_out, 16'h012C);
    run_op(2'd1, 8'd5, 8'd3, 0);     chk("sub_5_3", last_out, 16'h0002);
    run_op(2'd1, 8'd3, 8'd5, 0);     chk("sub_3_5", last_out, 16'hFFFE);
    run_op(2'd2, 8'd255, 8'd255, 0); chk("mul_255", last_out, 16'hFE01);
    run_op(2'd2, 8'd2, 8'd3, 0);     chk("mul_2_3", last_out, 16'h0006);
`ifdef SEQ_ALU_DIV_EN
    run_op(2'd3, 8'd100, 8'd7, 0);   chk("div_100_7", last_out, 16'h020E); chk("div_100_7_dz", last_dz, 0);
    run_op(2'd3, 8'd6, 8'd3, 0);     chk("div_6_3", last_out, 16'h0002);
    run_op(2'd3, 8'd9, 8'd0, 0);     chk("div_9_0", last_out, 16'h09FF); chk("div_9_0_dz", last_dz, 1);
`else
    run_op(2'd3, 8'd6, 8'd3, 0);     chk("nodiv_6_3", last_out, 16'h0000); chk("nodiv_dz", last_dz, 1);
`endif

    // Backpressure, then result and new operation handshake in the same cycle.
    @(negedge clk);
    in_valid = 1'b1; opcode = 2'd0; in1 = 8'd4; in2 = 8'd3;
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_out", out, 16'h0007);
      chk("bp_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; opcode = 2'd2; in1 = 8'd12; in2 = 8'd11;
    #1 chk("bp_hs_ready", in_ready, 1);
    chk("bp_hs_out", out, 16'h0007);
    @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("bp_mul_valid", out_valid, 1);
    chk("bp_mul_out", out, 16'd132);
    out_ready = 1'b1;
    @(posedge clk); #1 out_ready = 1'b0;

    // Reset while an operation is in flight discards it.
    @(negedge clk);
    in_valid = 1'b1;
`ifdef SEQ_ALU_DIV_EN
    opcode = 2'd3; in1 = 8'd200; in2 = 8'd3;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
`else
    opcode = 2'd0; in1 = 8'd200; in2 = 8'd3;
    @(posedge clk); #1 in_valid = 1'b0;
`endif
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_out", out, 0);
    seen = out_valid;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      seen = seen | out_valid;
    end
    chk("mid_rst_no_valid", seen, 0);
    run_op(2'd0, 8'd1, 8'd1, 0); chk("post_rst_add", last_out, 16'h0002);

    for (int n = 0; n < 150; n++) begin
      logic [7:0] a, b;
      a = 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 9) == 0) a = 8'hFF;
      run_op(2'($urandom), a, b, $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits (legal 2..32).
REQ-002 The block SHALL have a port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have a port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have a port in_valid, input, 1 bit: an operation is presented.
REQ-005 The block SHALL have a port in_ready, output, 1 bit: the block accepts an operation this cycle.
REQ-006 The block SHALL have ports in1 and in2, input, WIDTH bits each: unsigned operands.
REQ-007 The block SHALL have a port opcode, input, 2 bits: 00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-008 The block SHALL have a port out, output, 2*WIDTH bits: the result.
REQ-009 The block SHALL have a port out_valid, output, 1 bit: out is valid.
REQ-010 The block SHALL have a port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have a port div_zero, output, 1 bit: the current result came from a divide by zero; qualified by out_valid.

Function
REQ-012 The block SHALL accept an operation when in_valid && in_ready, and SHALL capture operands and opcode that cycle.
REQ-013 The FSM SHALL have states IDLE, BUSY and DONE.
- IDLE -> DONE on accept of ADD/SUB/MUL, or of DIV with in2==0.
- IDLE -> BUSY on accept of DIV with in2!=0.
REQ-014 BUSY SHALL run a restoring divider for exactly WIDTH cycles, then go to DONE.
REQ-015 DONE SHALL assert out_valid; on out_ready it SHALL go to IDLE, or stay in DONE/BUSY if a new operation is accepted the same cycle.
REQ-016 in_ready SHALL be (state==IDLE) || (state==DONE && out_ready); it SHALL be 0 in BUSY.
REQ-017 Latency from the accept cycle N SHALL be: out_valid at N+1 for ADD/SUB/MUL and divide-by-zero; at N+WIDTH+1 for DIV.
REQ-018 ADD SHALL produce out = zero-extended in1 + in2, where the carry appears in bit WIDTH.
REQ-019 SUB SHALL produce out = (in1 - in2) mod 2^(2*WIDTH), where operands are zero-extended, so a negative result wraps.
REQ-020 MUL SHALL produce out = the full unsigned product in1*in2.
REQ-021 DIV SHALL produce out[WIDTH-1:0] = quotient and out[2*WIDTH-1:WIDTH] = remainder.
REQ-022 Divide by zero SHALL give quotient all-ones, remainder = in1, and div_zero=1; div_zero SHALL be 0 for every other result.
REQ-023 While out_valid && !out_ready, out, div_zero and out_valid SHALL hold stable.

Reset
REQ-024 When rst is high at a rising clk edge, the next state SHALL be IDLE with out=0, out_valid=0, div_zero=0 and in_ready=1.
REQ-025 Reset SHALL take priority over an accept in the same cycle.
REQ-026 Reset in BUSY or DONE SHALL discard the operation; no out_valid SHALL follow.

Configuration
REQ-027 The macro SEQ_ALU_DIV_EN SHALL control whether division is compiled in.
- Defined: DIV behaves as in REQ-014..REQ-022.
- Undefined: no divider logic is built. An accepted DIV completes at N+1 with out=0 and div_zero=1, and BUSY is unreachable.

Structure
REQ-028 Package seq_alu_pkg SHALL hold the opcode enum (OP_ADD, OP_SUB, OP_MUL, OP_DIV) and the FSM state enum.
REQ-029 The iterative divider SHALL be a sub-module seq_alu_div, with ports start, dividend, divisor, done, quotient and remainder, instantiated only under SEQ_ALU_DIV_EN.

Verification (WIDTH=8, SEQ_ALU_DIV_EN defined unless noted)
REQ-030 The bench SHALL cover these directed scenarios:
- ADD 200+100 accepted at cycle N -> out=0x012C, out_valid at N+1; SUB 5-3 -> 0x0002; SUB 3-5 -> 0xFFFE.
- MUL 255*255 -> out=0xFE01 at N+1; MUL 2*3 -> 0x0006.
- DIV 100/7 -> in_ready=0 for cycles N+1..N+8, then out=0x020E and div_zero=0 at N+9; DIV 6/3 -> 0x0002.
- DIV 9/0 -> out=0x09FF, div_zero=1 at N+1; without SEQ_ALU_DIV_EN, DIV 6/3 -> out=0x0000, div_zero=1 at N+1.
- Backpressure: out_ready=0 for 5 cycles after an ADD 4+3 -> out=0x0007 held stable and in_ready=0; then out_ready=1 with a new MUL presented -> both handshakes complete in the same cycle and the MUL result appears the next cycle.
- rst pulsed at N+4 during DIV 200/3 -> IDLE next cycle, out_valid never asserts, and a following ADD 1+1 -> 0x0002 at the normal latency.
